regfile_multiport: RTL and testbench



---
 rtl/regfile_multiport.sv | 160 ++++++++++++++++
 tb/tb_regfile_multiport.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_multiport.sv
// regfile_multiport
//   Parametrised register file for the decode stage of the pipelined MIPS
//   datapath. It has NUM_RD registered read ports and one write port.
//   Register 0 always reads as zero. After reset, or when Clear_Req is
//   pulsed, a sweep writes zero to one entry per cycle. The storage keeps a
//   single plain write port, so it can still be inferred as RAM/LUTRAM.
//
//   Optional feature macro: REGFILE_BYPASS_EN
//     defined   - a read that hits the address being written on the same
//                 edge returns the new write data (write-through).
//     undefined - that read returns the value the entry held before the write.
//
// Parameters
//   DATA_W  register width in bits
//   ADDR_W  register index width
//   DEPTH   number of registers (2 .. 2**ADDR_W)
//   NUM_RD  number of read ports (1 .. 4)
//
// Ports
//   Clk        clock, all state changes on the rising edge
//   Rst        synchronous active-high reset; starts the clear sweep
//   Read_Reg   read addresses, port k at [k*ADDR_W +: ADDR_W]
//   Read_Dat   registered read data, port k at [k*DATA_W +: DATA_W]
//   Reg_Write  write enable
//   Write_Reg  write address
//   Write_Dat  write data
//   Clear_Req  one-cycle request to re-zero the whole array
//   Ready      high when the array is usable (sweep finished)

module regfile_multiport #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 2**ADDR_W,
  parameter int NUM_RD = 2
) (
  input  logic                     Clk,
  input  logic                     Rst,
  input  logic [NUM_RD*ADDR_W-1:0] Read_Reg,
  output logic [NUM_RD*DATA_W-1:0] Read_Dat,
  input  logic                     Reg_Write,
  input  logic [ADDR_W-1:0]        Write_Reg,
  input  logic [DATA_W-1:0]        Write_Dat,
  input  logic                     Clear_Req,
  output logic                     Ready
);

  // Storage index width. It is never wider than ADDR_W because
  // DEPTH <= 2**ADDR_W.
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  if (NUM_RD < 1 || NUM_RD > 4) begin : g_bad_num_rd
    $error("regfile_multiport: NUM_RD must be 1..4");
  end
  if (DEPTH < 2 || DEPTH > 2**ADDR_W) begin : g_bad_depth
    $error("regfile_multiport: DEPTH must be 2..2**ADDR_W");
  end

  typedef enum logic {ST_CLEAR, ST_READY} state_t;

  state_t            state;
  logic [ADDR_W-1:0] cnt;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              wr_acc;
  logic              mem_we;
  logic [IDX_W-1:0]  mem_wa;
  logic [DATA_W-1:0] mem_wd;

  logic [DATA_W-1:0] rd_dat_p1 [NUM_RD];

  // An address is backed by storage when it is nonzero and below DEPTH.
  // Reads of any other address return zero, and writes to them are dropped.
  function automatic logic addr_live(input logic [ADDR_W-1:0] a);
    return (a != '0) && (32'(a) < DEPTH);
  endfunction

  // Control: sweep / ready state machine
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state <= ST_CLEAR;
      cnt   <= '0;
      Ready <= 1'b0;
    end else begin
      case (state)
        ST_CLEAR: begin
          // Clear_Req is ignored here, so the sweep is never restarted by it.
          if (cnt == LAST) begin
            state <= ST_READY;
            Ready <= 1'b1;
          end else begin
            cnt <= cnt + ADDR_W'(1);
          end
        end
        ST_READY: begin
          if (Clear_Req) begin
            state <= ST_CLEAR;
            cnt   <= '0;
            Ready <= 1'b0;
          end
        end
        default: begin
          state <= ST_CLEAR;
          cnt   <= '0;
          Ready <= 1'b0;
        end
      endcase
    end
  end

  // Single write port shared by the sweep and user writes. The two sources
  // never overlap because each one belongs to a different state.
  always_comb begin
    wr_acc = (state == ST_READY) && Reg_Write && addr_live(Write_Reg);
    mem_we = 1'b0;
    mem_wa = Write_Reg[IDX_W-1:0];
    mem_wd = Write_Dat;
    if (!Rst) begin
      if (state == ST_CLEAR) begin
        mem_we = 1'b1;
        mem_wa = cnt[IDX_W-1:0];
        mem_wd = '0;
      end else if (wr_acc) begin
        mem_we = 1'b1;
      end
    end
  end

  // Storage has no reset, so it can map onto RAM primitives.
  always_ff @(posedge Clk) begin
    if (mem_we) begin
      mem[mem_wa] <= mem_wd;
    end
  end

  // Stage p1: registered read ports
  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    assign ra = Read_Reg[k*ADDR_W +: ADDR_W];

    always_ff @(posedge Clk) begin
      if (Rst) begin
        rd_dat_p1[k] <= '0;
      end else if (state != ST_READY || !addr_live(ra)) begin
        rd_dat_p1[k] <= '0;
`ifdef REGFILE_BYPASS_EN
      end else if (wr_acc && (Write_Reg == ra)) begin
        // wr_acc already excludes CLEAR state and address 0.
        rd_dat_p1[k] <= Write_Dat;
`endif
      end else begin
        rd_dat_p1[k] <= mem[ra[IDX_W-1:0]];
      end
    end

    assign Read_Dat[k*DATA_W +: DATA_W] = rd_dat_p1[k];
  end

endmodule

// File: tb/tb_regfile_multiport.sv
module tb_regfile_multiport;

  localparam int AW = 5;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic          Rst = 1'b1;
  logic          Reg_Write = 1'b0;
  logic          Clear_Req = 1'b0;
  logic [AW-1:0] Write_Reg = '0;
  logic [31:0]   Write_Dat = '0;
  logic [AW-1:0] rr [4];

  logic [2*AW-1:0] rd_reg_a;
  logic [3*AW-1:0] rd_reg_b;
  logic [63:0]     rd_dat_a;
  logic [47:0]     rd_dat_b;
  logic            ready_a, ready_b;

  assign rd_reg_a = {rr[1], rr[0]};
  assign rd_reg_b = {rr[2], rr[1], rr[0]};

  // Instance A: default configuration (32 x 32, two ports).
  regfile_multiport u_a (
    .Clk       (Clk),
    .Rst       (Rst),
    .Read_Reg  (rd_reg_a),
    .Read_Dat  (rd_dat_a),
    .Reg_Write (Reg_Write),
    .Write_Reg (Write_Reg),
    .Write_Dat (Write_Dat),
    .Clear_Req (Clear_Req),
    .Ready     (ready_a)
  );

  // Instance B: 16 x 16, three ports, depth below 2**ADDR_W.
  regfile_multiport #(.DATA_W(16), .ADDR_W(5), .DEPTH(16), .NUM_RD(3)) u_b (
    .Clk       (Clk),
    .Rst       (Rst),
    .Read_Reg  (rd_reg_b),
    .Read_Dat  (rd_dat_b),
    .Reg_Write (Reg_Write),
    .Write_Reg (Write_Reg),
    .Write_Dat (Write_Dat[15:0]),
    .Clear_Req (Clear_Req),
    .Ready     (ready_b)
  );

  typedef struct packed {
    logic             rdy;
    logic [3:0][31:0] dat;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];

  // Reference model: contents of each file, a ready flag and the number
  // of edges left in the current clear sweep.
  logic [31:0] m_reg  [2][32];
  bit          m_rdy  [2];
  int          m_left [2];
  bit          started = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input int port, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      if (n_bad <= 40)
        $display("FAIL %s port%0d at %0t: got %h expected %h", nm, port, $time, act, exp);
    end
  endtask

  task automatic model_edge(input int i, output exp_t e);
    int          d;
    int          n;
    logic [31:0] msk;
    logic [31:0] wd;
    bit          wacc;
    d   = (i == 0) ? 32 : 16;
    n   = (i == 0) ? 2 : 3;
    msk = (i == 0) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
    wd  = Write_Dat & msk;
    e   = '0;
    if (Rst) begin
      m_rdy[i]  = 1'b0;
      m_left[i] = d;
      for (int j = 0; j < 32; j++) m_reg[i][j] = '0;
    end else if (!m_rdy[i]) begin
      m_left[i]--;
      if (m_left[i] == 0) m_rdy[i] = 1'b1;
    end else begin
      wacc = Reg_Write && (Write_Reg != 0) && (int'(Write_Reg) < d);
      for (int k = 0; k < n; k++) begin
        if (rr[k] != 0 && int'(rr[k]) < d) begin
          if (BYP && wacc && Write_Reg == rr[k]) e.dat[k] = wd;
          else                                  e.dat[k] = m_reg[i][rr[k]];
        end
      end
      if (wacc) m_reg[i][Write_Reg] = wd;
      if (Clear_Req) begin
        m_rdy[i]  = 1'b0;
        m_left[i] = d;
        for (int j = 0; j < 32; j++) m_reg[i][j] = '0;
      end
    end
    e.rdy = m_rdy[i];
  endtask

  // Drive one rising edge and queue what both files must show after it.
  task automatic tick();
    exp_t ea, eb;
    @(posedge Clk);
    if (Rst) started = 1'b1;
    if (started) begin
      model_edge(0, ea);
      model_edge(1, eb);
      qa.push_back(ea);
      qb.push_back(eb);
    end
    #1;
  endtask

  task automatic idle_rand_reads();
    Rst = 1'b0; Reg_Write = 1'b0; Clear_Req = 1'b0;
    for (int k = 0; k < 4; k++) rr[k] = AW'($urandom_range(0, 31));
  endtask

  task automatic set_reads(input logic [AW-1:0] a);
    for (int k = 0; k < 4; k++) rr[k] = a;
  endtask

  // Monitor: checks the outputs on every falling edge that has an expectation.
  initial begin
    exp_t ea, eb;
    forever begin
      @(negedge Clk);
      if (qa.size() > 0 && qb.size() > 0) begin
        ea = qa.pop_front();
        eb = qb.pop_front();
        chk("ready_a", 0, {31'b0, ready_a}, {31'b0, ea.rdy});
        chk("ready_b", 0, {31'b0, ready_b}, {31'b0, eb.rdy});
        for (int k = 0; k < 2; k++) chk("rdat_a", k, rd_dat_a[k*32 +: 32], ea.dat[k]);
        for (int k = 0; k < 3; k++) chk("rdat_b", k, {16'b0, rd_dat_b[k*16 +: 16]}, eb.dat[k]);
      end
    end
  end

  initial begin
    for (int k = 0; k < 4; k++) rr[k] = '0;

    // Reset, then the sweep while writes and clear requests are ignored.
    Rst = 1'b1;
    tick();
    for (int c = 0; c < 40; c++) begin
      idle_rand_reads();
      Reg_Write = c < 32;
      Write_Reg = AW'($urandom_range(1, 31));
      Write_Dat = $urandom | 32'h1;
      Clear_Req = (c == 5);
      tick();
    end

    // Write r5, then read it on both ports.
    idle_rand_reads();
    Reg_Write = 1'b1; Write_Reg = 5'd5; Write_Dat = 32'hDEAD_BEEF;
    tick();
    Reg_Write = 1'b0; set_reads(5'd5);
    tick();
    tick();

    // A write to r0 is discarded.
    Reg_Write = 1'b1; Write_Reg = 5'd0; Write_Dat = 32'h1234_5678;
    tick();
    Reg_Write = 1'b0; set_reads(5'd0);
    tick();

    // Same-edge write and read of r7.
    Reg_Write = 1'b1; Write_Reg = 5'd7; Write_Dat = 32'h0000_0001;
    tick();
    Write_Dat = 32'hA5A5_A5A5; set_reads(5'd7);
    tick();
    Reg_Write = 1'b0;
    tick();

    // Fill r1..r31, then a clear request with a write on the same edge.
    for (int r = 1; r < 32; r++) begin
      Reg_Write = 1'b1; Write_Reg = AW'(r); Write_Dat = $urandom | 32'h1;
      for (int k = 0; k < 4; k++) rr[k] = AW'($urandom_range(0, 31));
      tick();
    end
    Clear_Req = 1'b1; Write_Reg = 5'd9; Write_Dat = 32'h5555_AAAA;
    tick();
    for (int c = 0; c < 40; c++) begin
      idle_rand_reads();
      Reg_Write = 1'b1;
      Write_Reg = AW'($urandom_range(1, 31));
      Write_Dat = $urandom | 32'h1;
      tick();
    end
    Reg_Write = 1'b0;
    for (int r = 0; r < 32; r++) begin
      set_reads(AW'(r));
      rr[1] = AW'(31 - r);
      tick();
    end

    // Reset at sweep cycle 10.
    Rst = 1'b1;
    tick();
    idle_rand_reads();
    for (int c = 0; c < 10; c++) tick();
    Rst = 1'b1;
    tick();
    for (int c = 0; c < 40; c++) begin
      idle_rand_reads();
      tick();
    end

    // Randomised traffic with biased read/write collisions.
    for (int c = 0; c < 3000; c++) begin
      Rst       = ($urandom_range(0, 499) == 0);
      Clear_Req = ($urandom_range(0, 149) == 0);
      Reg_Write = $urandom_range(0, 1) == 1;
      Write_Reg = AW'($urandom_range(0, 31));
      Write_Dat = $urandom;
      for (int k = 0; k < 4; k++)
        rr[k] = ($urandom_range(0, 9) < 3) ? Write_Reg : AW'($urandom_range(0, 31));
      tick();
    end

    idle_rand_reads();
    tick();
    @(negedge Clk);
    @(negedge Clk);
    chk("queue_drained", 0, qa.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
